// File: rtl/tri_vertex_assembler.sv
// Rasterizer front end: assembles a stream of single vertices into list or strip
// triangles and holds each one in an output register until the bbox stage accepts it.
module tri_vertex_assembler #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         vert_valid,
  output logic                         vert_ready,
  input  logic [AXIS*SIGFIG-1:0]       vert_pos,
  input  logic [COLORS*SIGFIG-1:0]     vert_color,
  input  logic                         vert_first,
  input  logic                         vert_strip,
  output logic                         tri_valid,
  input  logic                         tri_ready,
  output logic [VERTS*AXIS*SIGFIG-1:0] tri_out,
  output logic [COLORS*SIGFIG-1:0]     color_out,
  output logic [CNT_W-1:0]             tri_count
);

  localparam int VW = AXIS * SIGFIG;
  localparam int CW = COLORS * SIGFIG;
  localparam int TW = VERTS * VW;

  typedef enum logic {
    MODE_LIST  = 1'b0,
    MODE_STRIP = 1'b1
  } mode_e;

  generate
    if (VERTS != 3 || RADIX > SIGFIG) begin : g_bad_params
      $error("tri_vertex_assembler: only VERTS=3 with RADIX<=SIGFIG is supported");
    end
  endgenerate

  logic [1:0]       n_q, n_d;
  mode_e            mode_q, mode_d;
  logic             par_q, par_d;
  logic [VW-1:0]    s0_q, s0_d;
  logic [VW-1:0]    s1_q, s1_d;
  logic [TW-1:0]    tri_q, tri_d;
  logic [CW-1:0]    color_q, color_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic completing;
  logic accept;
  logic emit;
  logic handoff;
  logic swap;

  // A vert_first beat restarts the primitive, so only a continuation beat with two
  // buffered vertices can produce a triangle and therefore be held off by a stall.
  assign completing = (n_q == 2'd2) && !vert_first;
  assign vert_ready = !(completing && valid_q && !tri_ready);
  assign accept     = vert_valid && vert_ready;
  assign emit       = accept && completing;
  assign handoff    = valid_q && tri_ready;

  // Odd strip triangles swap the two older vertices to keep a consistent winding.
  assign swap = (mode_q == MODE_STRIP) && par_q;

  logic [VW-1:0] tri_vert [VERTS];
  logic [TW-1:0] tri_asm;

  assign tri_vert[0] = swap ? s1_q : s0_q;
  assign tri_vert[1] = swap ? s0_q : s1_q;
  assign tri_vert[2] = vert_pos;

  generate
    for (genvar gi = 0; gi < VERTS; gi++) begin : g_pack
      assign tri_asm[gi*VW +: VW] = tri_vert[gi];
    end
  endgenerate

  always_comb begin
    n_d     = n_q;
    mode_d  = mode_q;
    par_d   = par_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    tri_d   = tri_q;
    color_d = color_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    if (accept) begin
      if (vert_first) begin
        s0_d   = vert_pos;
        n_d    = 2'd1;
        par_d  = 1'b0;
        mode_d = vert_strip ? MODE_STRIP : MODE_LIST;
      end else begin
        case (n_q)
          2'd0: begin
            s0_d = vert_pos;
            n_d  = 2'd1;
          end
          2'd1: begin
            s1_d = vert_pos;
            n_d  = 2'd2;
          end
          default: begin
            if (mode_q == MODE_LIST) begin
              n_d = 2'd0;
            end else begin
              s0_d  = s1_q;
              s1_d  = vert_pos;
              par_d = ~par_q;
            end
          end
        endcase
      end
    end

    // A new triangle overrides a same-cycle handoff so the register never bubbles.
    if (emit) begin
      tri_d   = tri_asm;
      color_d = vert_color;
      valid_d = 1'b1;
    end else if (handoff) begin
      valid_d = 1'b0;
    end

    if (handoff) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q     <= 2'd0;
      mode_q  <= MODE_LIST;
      par_q   <= 1'b0;
      s0_q    <= '0;
      s1_q    <= '0;
      tri_q   <= '0;
      color_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      n_q     <= n_d;
      mode_q  <= mode_d;
      par_q   <= par_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      tri_q   <= tri_d;
      color_q <= color_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tri_valid = valid_q;
  assign tri_out   = tri_q;
  assign color_out = color_q;
  assign tri_count = cnt_q;

endmodule

// File: tb/tb_tri_vertex_assembler.sv
// Randomized and directed bench for tri_vertex_assembler: a topology-level reference
// model fills a scoreboard that an independent monitor drains on every handoff.
module tb_tri_vertex_assembler;

  localparam int SIGFIG = 24;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;
  localparam int VERTS  = 3;
  localparam int CNT_W  = 16;
  localparam int VW     = AXIS * SIGFIG;
  localparam int CW     = COLORS * SIGFIG;
  localparam int TW     = VERTS * VW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              vert_valid = 1'b0;
  logic              vert_ready;
  logic [VW-1:0]     vert_pos = '0;
  logic [CW-1:0]     vert_color = '0;
  logic              vert_first = 1'b0;
  logic              vert_strip = 1'b0;
  logic              tri_valid;
  logic              tri_ready = 1'b0;
  logic [TW-1:0]     tri_out;
  logic [CW-1:0]     color_out;
  logic [CNT_W-1:0]  tri_count;

  tri_vertex_assembler dut (
    .clk        (clk),
    .rst        (rst),
    .vert_valid (vert_valid),
    .vert_ready (vert_ready),
    .vert_pos   (vert_pos),
    .vert_color (vert_color),
    .vert_first (vert_first),
    .vert_strip (vert_strip),
    .tri_valid  (tri_valid),
    .tri_ready  (tri_ready),
    .tri_out    (tri_out),
    .color_out  (color_out),
    .tri_count  (tri_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] t;
    logic [CW-1:0] c;
  } exp_t;

  exp_t          sb[$];
  logic [VW-1:0] mv[$];
  bit            mstrip = 1'b0;
  int            midx = 0;
  int            checks = 0;
  int            errors = 0;
  int            handoffs = 0;
  logic [15:0]   exp_cnt = '0;
  bit            quiet = 1'b0;

  logic [VW-1:0] v[6];
  logic [CW-1:0] c[6];

  function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [VW-1:0] mkv(int x);
    return {24'($urandom), 24'($urandom), 24'(x)};
  endfunction

  function automatic logic [71:0] xs(logic [TW-1:0] t);
    return {t[2*VW +: 24], t[VW +: 24], t[0 +: 24]};
  endfunction

  // Reference model: the primitive's vertex history, from which each triangle is
  // taken as the last three vertices (list: every third; strip: every vertex from
  // the third, odd triangles with their two older vertices exchanged).
  function automatic void model_reset();
    mv.delete();
    mstrip = 1'b0;
    midx   = 0;
  endfunction

  function automatic void model_accept(logic [VW-1:0] p, logic [CW-1:0] col, bit f, bit s);
    exp_t e;
    if (f) begin
      mv.delete();
      mstrip = s;
      midx   = 0;
    end
    mv.push_back(p);
    if (mv.size() == 3) begin
      if (!mstrip) begin
        e.t = {mv[2], mv[1], mv[0]};
        mv.delete();
      end else begin
        e.t = (midx % 2 == 0) ? {mv[2], mv[1], mv[0]} : {mv[2], mv[0], mv[1]};
        midx++;
        void'(mv.pop_front());
      end
      e.c = col;
      sb.push_back(e);
    end
  endfunction

  task automatic beat(input logic [VW-1:0] p, input logic [CW-1:0] col, input bit f,
                      input bit s, input int rdy, output bit acc);
    @(negedge clk);
    vert_valid = 1'b1;
    vert_pos   = p;
    vert_color = col;
    vert_first = f;
    vert_strip = s;
    tri_ready  = (rdy == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy);
    #4;
    acc = vert_ready;
    if (acc) model_accept(p, col, f, s);
    @(posedge clk);
  endtask

  task automatic send(input logic [VW-1:0] p, input logic [CW-1:0] col, input bit f,
                      input bit s, input int rdy);
    bit acc;
    int tries;
    tries = 0;
    do begin
      beat(p, col, f, s, rdy, acc);
      tries++;
    end while (!acc && tries < 200);
    if (!acc) chk("send_timeout", 256'(acc), 256'(1));
  endtask

  task automatic idle(input int n, input int rdy);
    repeat (n) begin
      @(negedge clk);
      vert_valid = 1'b0;
      vert_first = 1'b0;
      tri_ready  = (rdy == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy);
      @(posedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    vert_valid = 1'b0;
    vert_first = 1'b0;
    tri_ready  = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: compares the presented triangle against the scoreboard head every cycle
  // (which also proves stability under stall) and pops it on a handoff.
  initial begin : monitor
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        sb.delete();
        exp_cnt = '0;
      end else begin
        chk("tri_count", 256'(tri_count), 256'(exp_cnt));
        if (tri_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_tri", 256'(tri_valid), 256'(0));
          end else begin
            chk("tri_out", 256'(tri_out), 256'(sb[0].t));
            chk("color_out", 256'(color_out), 256'(sb[0].c));
            if (tri_ready) begin
              if (!quiet)
                $display("TRI %0d handoff x={%0d,%0d,%0d} color=%h", handoffs,
                         tri_out[2*VW +: 24], tri_out[VW +: 24], tri_out[0 +: 24], color_out);
              void'(sb.pop_front());
              exp_cnt = exp_cnt + 16'd1;
              handoffs++;
            end
          end
        end else begin
          chk("tri_pending", 256'(sb.size()), 256'(0));
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit acc;
    int h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_tri_valid", 256'(tri_valid), 256'(0));
    chk("rst_tri_out", 256'(tri_out), 256'(0));
    chk("rst_color_out", 256'(color_out), 256'(0));
    chk("rst_tri_count", 256'(tri_count), 256'(0));
    chk("rst_vert_ready", 256'(vert_ready), 256'(1));

    // List mode with the bbox always ready
    for (int k = 0; k < 6; k++) begin
      v[k] = mkv(1024 * (k + 1));
      c[k] = {24'($urandom), 24'($urandom), 24'($urandom)};
    end
    for (int k = 0; k < 6; k++) begin
      send(v[k], c[k], k == 0, 1'b0, 1);
      if (k == 2 || k == 5) begin
        #1;
        chk("list_valid", 256'(tri_valid), 256'(1));
        chk("list_x", 256'(xs(tri_out)),
            (k == 2) ? 256'({24'd3072, 24'd2048, 24'd1024}) : 256'({24'd6144, 24'd5120, 24'd4096}));
        chk("list_color", 256'(color_out), 256'(c[k]));
      end
    end
    idle(2, 1);
    chk("list_count", 256'(tri_count), 256'(2));

    // Strip A..E
    h0 = int'(tri_count);
    for (int k = 0; k < 5; k++) begin
      beat(mkv(100 * (k + 1)), {24'($urandom), 24'($urandom), 24'($urandom)}, k == 0, 1'b1, 1, acc);
      chk("strip_ready", 256'(acc), 256'(1));
    end
    idle(2, 1);
    chk("strip_count", 256'(tri_count), 256'(h0 + 3));

    // Backpressure on the first triangle
    do_reset();
    for (int k = 0; k < 3; k++) send(v[k], c[k], k == 0, 1'b0, (k == 2) ? 0 : 1);
    beat(v[3], c[3], 1'b0, 1'b0, 0, acc);
    chk("bp_accept4", 256'(acc), 256'(1));
    beat(v[4], c[4], 1'b0, 1'b0, 0, acc);
    chk("bp_accept5", 256'(acc), 256'(1));
    for (int k = 0; k < 2; k++) begin
      beat(v[5], c[5], 1'b0, 1'b0, 0, acc);
      chk("bp_stall_ready", 256'(acc), 256'(0));
    end
    #1;
    chk("bp_hold_x", 256'(xs(tri_out)), 256'({24'd3072, 24'd2048, 24'd1024}));
    beat(v[5], c[5], 1'b0, 1'b0, 1, acc);
    chk("bp_release_accept", 256'(acc), 256'(1));
    #1;
    chk("bp_second_valid", 256'(tri_valid), 256'(1));
    chk("bp_count", 256'(tri_count), 256'(1));
    chk("bp_second_x", 256'(xs(tri_out)), 256'({24'd6144, 24'd5120, 24'd4096}));
    idle(3, 1);

    // Restart discards partial vertices
    do_reset();
    send(mkv(11), c[0], 1'b0, 1'b0, 1);
    send(mkv(22), c[1], 1'b0, 1'b0, 1);
    send(mkv(33), c[2], 1'b1, 1'b0, 1);
    send(mkv(44), c[3], 1'b0, 1'b0, 1);
    send(mkv(55), c[4], 1'b0, 1'b0, 1);
    #1;
    chk("restart_x", 256'(xs(tri_out)), 256'({24'd55, 24'd44, 24'd33}));
    idle(3, 1);
    chk("restart_count", 256'(tri_count), 256'(1));

    // Reset while a triangle is stalled and one vertex is buffered
    for (int k = 0; k < 4; k++) send(v[k], c[k], k == 0, 1'b0, 0);
    idle(1, 0);
    #1;
    chk("pre_rst_valid", 256'(tri_valid), 256'(1));
    do_reset();
    #1;
    chk("mid_rst_valid", 256'(tri_valid), 256'(0));
    chk("mid_rst_count", 256'(tri_count), 256'(0));
    chk("mid_rst_ready", 256'(vert_ready), 256'(1));
    for (int k = 0; k < 3; k++) send(v[k + 3], c[k + 3], 1'b0, 1'b0, 1);
    idle(3, 1);
    chk("mid_rst_after", 256'(tri_count), 256'(1));

    // Randomized topology, restarts and backpressure
    do_reset();
    for (int k = 0; k < 300; k++)
      send(mkv(int'($urandom)), {24'($urandom), 24'($urandom), 24'($urandom)},
           $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)), 2);
    idle(6, 1);
    chk("random_drain", 256'(sb.size()), 256'(0));

    // Counter wrap over 65536 back-to-back strip triangles
    do_reset();
    quiet = 1'b1;
    h0 = handoffs;
    send(mkv(1), c[0], 1'b1, 1'b1, 1);
    for (int k = 0; k < 65537; k++) send(mkv(k + 2), c[k % 6], 1'b0, 1'b0, 1);
    idle(4, 1);
    quiet = 1'b0;
    chk("wrap_count", 256'(tri_count), 256'(0));
    chk("wrap_handoffs", 256'(handoffs - h0), 256'(65536));
    chk("wrap_drain", 256'(sb.size()), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tri_vertex_assembler.md
Name: tri_vertex_assembler

Overview:
- Front end of the rasterizer. Accepts a stream of single vertices (position plus color), assembles them into micropolygons of VERTS vertices, and presents each triangle to the bbox stage.
- Acts as the transmitter side of the bbox triangle-input interface, with a valid/ready handshake on each side.
- Supports triangle-list and triangle-strip topologies.

Parameters:
- SIGFIG, 24, bits per coordinate/color component (from rast_params).
- RADIX, 10, fraction bits; carried only, no arithmetic performed.
- VERTS, 3, vertices per triangle; the block supports only 3.
- AXIS, 3, coordinates per vertex (x,y,z).
- COLORS, 3, color channels.
- CNT_W, 16, width of the emitted-triangle counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- vert_valid  in  1  vertex beat valid.
- vert_ready  out  1  vertex beat accepted when vert_valid & vert_ready.
- vert_pos  in  AXIS*SIGFIG  vertex {z,y,x}, x in LSBs.
- vert_color  in  COLORS*SIGFIG  vertex color.
- vert_first  in  1  beat starts a new primitive; discards any partial vertices.
- vert_strip  in  1  topology, sampled only on a vert_first beat: 1=strip, 0=list.
- tri_valid  out  1  triangle presented to bbox.
- tri_ready  in  1  bbox accepts the triangle (not halted).
- tri_out  out  VERTS*AXIS*SIGFIG  {v2,v1,v0}, v0 in LSBs.
- color_out  out  COLORS*SIGFIG  triangle color.
- tri_count  out  CNT_W  triangles handed off (tri_valid & tri_ready), wraps.

Behaviour:
- Reset (synchronous, rst high at posedge):
  - tri_valid=0, tri_out=0, color_out=0, tri_count=0.
  - Vertex slots cleared, fill count=0, mode=list, strip parity=0.
  - vert_ready is 1 after reset.
  - Reset mid-operation drops any held triangle and any partial vertices.
- State:
  - fill count n in 0..2 (vertices buffered).
  - mode register; strip parity bit p.
  - two vertex slots s0,s1.
  - output register holding tri_out/color_out/tri_valid.
- Accept rule: vert_ready = !(completing & tri_valid & !tri_ready).
  - completing is true when the incoming beat would finish a triangle: n==2, with vert_first=0.
  - A vert_first beat never completes a triangle, because it resets n.
  - A non-completing vertex is always accepted, even while the output is stalled.
- On an accepted beat with vert_first=1: s0<=vert_pos, n<=1, p<=0, mode<=vert_strip. Partial data is dropped silently.
- On an accepted beat with vert_first=0:
  - n==0: store to s0.
  - n==1: store to s1.
  - n==2: emit a triangle. color_out <= vert_color (provoking vertex is the last one).
    - List mode: tri_out <= {vert,s1,s0}; n<=0.
    - Strip mode, p=0: tri_out <= {vert,s1,s0}.
    - Strip mode, p=1: tri_out <= {vert,s0,s1}, swapping to preserve winding.
    - Strip mode, both parities: s0<=s1, s1<=vert, p<=~p, n stays 2.
- Output register:
  - tri_valid is set on the cycle after the completing beat (latency 1).
  - tri_valid stays set with tri_out stable until tri_valid & tri_ready.
  - Handoff and a new completing beat in the same cycle: the new triangle is loaded and tri_valid stays 1, giving back-to-back throughput of 1 triangle/clk.
  - tri_valid & tri_ready with no new triangle clears tri_valid at the next edge.
  - tri_ready is ignored when tri_valid=0.
- tri_count increments on each handoff; 0xFFFF wraps to 0.
- The first beat after reset is treated as if vert_first=1 when n==0. List mode is then the default unless vert_first asserts strip.
- Vertex data passes through without modification. No arithmetic, no sign or width change.

Test Plan:
- List, ready held 1:
  - Stimulus: 6 vertices, first with vert_first=1, vert_strip=0. x values 1024,2048,3072,4096,5120,6144; colors c0..c5.
  - Response: tri_valid on the cycle after beat 3 with tri_out x={3072,2048,1024}, color_out=c2. After beat 6: x={6144,5120,4096}, color_out=c5. tri_count=2.
- Strip:
  - Stimulus: 5 vertices A..E with vert_first+strip on A.
  - Response: triangles {C,B,A}, {D,B,C}, {E,D,C}, in that order. vert_ready stays 1 throughout.
- Backpressure:
  - Stimulus: list mode, tri_ready=0 after the first triangle. Feed vertices 4,5,6.
  - Response: 4 and 5 are accepted. vert_ready=0 while 6 is presented. tri_out stays stable.
  - When tri_ready=1 for one cycle: the first triangle hands off and 6 is accepted in the same cycle. The second triangle is valid the next cycle; tri_count=1.
- Restart: after 2 list vertices, a beat with vert_first=1 discards them. Three further vertices emit exactly one triangle, made of the new beats only.
- Reset mid-stall:
  - Stimulus: assert rst while tri_valid=1, tri_ready=0, and n=1.
  - Response: the next cycle shows tri_valid=0, tri_count=0, vert_ready=1. The next 3 vertices yield one triangle.
- Counter wrap: hand off 65536 triangles. tri_count returns to 0 and no triangle is lost; checked by scoreboard.
